// File: rtl/mem_arr_skew_if.sv
// Bus bundle for the banked scratchpad: per-bank write/read lanes plus the
// skewed-stream command and status signals.
interface mem_arr_skew_if #(
   parameter int NUM_BANKS = 4,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8
);
   logic [NUM_BANKS-1:0]        wr_en;
   logic [NUM_BANKS*ADDR_W-1:0] wr_addr;
   logic [NUM_BANKS*DATA_W-1:0] wr_data;
   logic [NUM_BANKS-1:0]        rd_en;
   logic [NUM_BANKS*ADDR_W-1:0] rd_addr;
   logic                        stream_start;
   logic [ADDR_W-1:0]           stream_base;
   logic [ADDR_W:0]             stream_len;
   logic [NUM_BANKS*DATA_W-1:0] rd_data;
   logic [NUM_BANKS-1:0]        rd_valid;
   logic                        stream_busy;
   logic                        stream_done;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output stream_start, stream_base, stream_len,
      input  rd_data, rd_valid, stream_busy, stream_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  stream_start, stream_base, stream_len,
      output rd_data, rd_valid, stream_busy, stream_done
   );
endinterface

// File: rtl/mem_arr_skew.sv
// Banked scratchpad with a diagonal-skew streaming read sequencer.
// Bank i lags bank 0 by i cycles so the output lanes can feed a systolic
// array edge directly. Each bank is a simple-dual-port RAM with a
// registered, read-before-write read port shared by host and stream.
module mem_arr_skew #(
   parameter int NUM_BANKS = 4,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arr_skew_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   // Cycle counter must reach len + NUM_BANKS - 1 with len up to DEPTH.
   localparam int TW    = $clog2(DEPTH + NUM_BANKS) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state_r;
   logic [TW-1:0]     t_r;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W:0]   len_r;
   logic              busy_r;
   logic              done_r;
   logic              run_last_s;

   // Flag the RUN cycle in which the last bank issues its final row read.
   always_comb begin
      run_last_s = 1'b0;
      if ((t_r + TW'(1)) == (TW'(len_r) + TW'(NUM_BANKS - 1))) begin
         run_last_s = 1'b1;
      end else begin
         run_last_s = 1'b0;
      end
   end

   // Sequencer FSM with registered busy/done status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         t_r     <= '0;
         base_r  <= '0;
         len_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.stream_start) begin
                  base_r <= bus.stream_base;
                  len_r  <= bus.stream_len;
                  t_r    <= '0;
                  busy_r <= 1'b1;
                  if (bus.stream_len == '0) begin
                     // Empty stream: a single drain cycle that only signals completion.
                     state_r <= DRAIN;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= RUN;
                     done_r  <= 1'b0;
                  end
               end else begin
                  busy_r <= 1'b0;
                  done_r <= 1'b0;
               end
            end
            RUN: begin
               t_r    <= t_r + TW'(1);
               busy_r <= 1'b1;
               if (run_last_s) begin
                  // Last lane's data lands in the drain cycle, so done goes with it.
                  state_r <= DRAIN;
                  done_r  <= 1'b1;
               end else begin
                  done_r <= 1'b0;
               end
            end
            DRAIN: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               t_r     <= '0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.stream_busy = busy_r;
   assign bus.stream_done = done_r;

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic [DATA_W-1:0] mem [DEPTH];
      logic              fire_s;
      logic [ADDR_W-1:0] row_s;
      logic [TW-1:0]     lag_s;
      logic [DATA_W-1:0] q_r;
      logic              vld_r;

      // Pick this bank's read request: host lane in IDLE, skewed row in RUN.
      always_comb begin
         fire_s = 1'b0;
         row_s  = '0;
         lag_s  = t_r - TW'(g);
         case (state_r)
            IDLE: begin
               fire_s = bus.rd_en[g];
               row_s  = bus.rd_addr[g*ADDR_W +: ADDR_W];
            end
            RUN: begin
               // Bank g is active while g <= t < g + len; row wraps modulo depth.
               if ((t_r >= TW'(g)) && (lag_s < TW'(len_r))) begin
                  fire_s = 1'b1;
                  row_s  = base_r + lag_s[ADDR_W-1:0];
               end else begin
                  fire_s = 1'b0;
                  row_s  = '0;
               end
            end
            default: begin
               fire_s = 1'b0;
               row_s  = '0;
            end
         endcase
      end

      // Write port: active in every sequencer state; contents never reset.
      always_ff @(posedge clk) begin
         if (bus.wr_en[g]) begin
            mem[bus.wr_addr[g*ADDR_W +: ADDR_W]] <= bus.wr_data[g*DATA_W +: DATA_W];
         end
      end

      // Registered read port; a same-edge write is not visible (old data returned).
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q_r   <= '0;
            vld_r <= 1'b0;
         end else begin
            vld_r <= fire_s;
            if (fire_s) begin
               q_r <= mem[row_s];
            end
         end
      end

      assign bus.rd_data[g*DATA_W +: DATA_W] = q_r;
      assign bus.rd_valid[g]                 = vld_r;
   end
endmodule

// File: tb/tb_mem_arr_skew.sv
// Directed bench for mem_arr_skew (4 banks x 8 bits x 256 rows).
module tb_mem_arr_skew;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   done_cnt;

   mem_arr_skew_if #(.NUM_BANKS(4), .DATA_W(8), .ADDR_W(8)) bus ();

   mem_arr_skew #(.NUM_BANKS(4), .DATA_W(8), .ADDR_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  wr_en;
      logic [31:0] wr_addr;
      logic [31:0] wr_data;
      logic [3:0]  rd_en;
      logic [31:0] rd_addr;
      logic        start;
      logic [7:0]  base;
      logic [8:0]  len;
      logic [3:0]  exp_valid;
      logic [3:0]  chk_lanes;
      logic [31:0] exp_data;
      logic        exp_busy;
      logic        exp_done;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic [3:0] we, input logic [31:0] wa, input logic [31:0] wd,
                               input logic [3:0] re, input logic [31:0] ra, input logic st,
                               input logic [7:0] b, input logic [8:0] l, input logic [3:0] ev,
                               input logic [3:0] ck, input logic [31:0] edat, input logic eb,
                               input logic edn);
      vec_t v;
      v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.rd_en = re; v.rd_addr = ra;
      v.start = st; v.base = b; v.len = l; v.exp_valid = ev; v.chk_lanes = ck;
      v.exp_data = edat; v.exp_busy = eb; v.exp_done = edn;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (bus.stream_done === 1'b1) done_cnt++;
   endtask

   task automatic idle_inputs();
      bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.rd_en = '0; bus.rd_addr = '0;
      bus.stream_start = 1'b0; bus.stream_base = '0; bus.stream_len = '0;
   endtask

   // Fill the same row of every bank with {bank, row[3:0]}.
   task automatic write_row(input logic [7:0] row);
      bus.wr_en = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         bus.wr_addr[i*8 +: 8] = row;
         bus.wr_data[i*8 +: 8] = 8'(i * 16) | {4'h0, row[3:0]};
      end
      step();
      idle_inputs();
   endtask

   // Start a stream and check every lane, cycle by cycle, until it drains.
   task automatic stream_chk(input string nm, input logic [7:0] base, input int len);
      logic [3:0] ev;
      logic [7:0] row;
      bus.stream_start = 1'b1; bus.stream_base = base; bus.stream_len = 9'(len);
      step();
      idle_inputs();
      chk({nm, "_start_busy"}, 32'(bus.stream_busy), 32'h1);
      chk({nm, "_start_valid"}, 32'(bus.rd_valid), 32'h0);
      for (int k = 1; k <= len + 3; k++) begin
         step();
         ev = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            if ((k - 1 >= i) && (k - 1 < i + len)) ev[i] = 1'b1;
         end
         chk($sformatf("%s_k%0d_valid", nm, k), 32'(bus.rd_valid), 32'(ev));
         chk($sformatf("%s_k%0d_busy", nm, k), 32'(bus.stream_busy), 32'h1);
         chk($sformatf("%s_k%0d_done", nm, k), 32'(bus.stream_done), (k == len + 3) ? 32'h1 : 32'h0);
         for (int i = 0; i < 4; i++) begin
            if (ev[i]) begin
               row = 8'(int'(base) + k - 1 - i);
               chk($sformatf("%s_k%0d_lane%0d", nm, k, i), 32'(bus.rd_data[i*8 +: 8]),
                   32'(8'(i * 16) | {4'h0, row[3:0]}));
            end
         end
      end
      step();
      chk({nm, "_after_busy"}, 32'(bus.stream_busy), 32'h0);
      chk({nm, "_after_valid"}, 32'(bus.rd_valid), 32'h0);
   endtask

   initial begin
      int done_before;
      total = 0; bad = 0; done_cnt = 0;
      idle_inputs();
      rst_n = 1'b0;
      #22;
      chk("rst_data", bus.rd_data, 32'h0);
      chk("rst_valid", 32'(bus.rd_valid), 32'h0);
      chk("rst_busy", 32'(bus.stream_busy), 32'h0);
      chk("rst_done", 32'(bus.stream_done), 32'h0);
      rst_n = 1'b1;
      #10;

      for (int r = 0; r < 8; r++) write_row(8'(r));
      write_row(8'hFE);
      write_row(8'hFF);

      // Vector table: inputs presented for one cycle, outputs checked just after the edge.
      vq.push_back(mk(4'b0100, 32'h00100000, 32'h00A50000, 4'b0000, 32'h0, 1'b0, 8'h00, 9'd0,
                      4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0));               // host write
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0100, 32'h00100000, 1'b0, 8'h00, 9'd0,
                      4'b0100, 4'b0100, 32'h00A50000, 1'b0, 1'b0));        // host read back
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 8'h00, 9'd0,
                      4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0));               // no read, no valid
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b1111, 32'h05050505, 1'b0, 8'h00, 9'd0,
                      4'b1111, 4'b1111, 32'h35251505, 1'b0, 1'b0));        // all-bank read
      vq.push_back(mk(4'b0010, 32'h00000300, 32'h00007700, 4'b0010, 32'h00000300, 1'b0, 8'h00, 9'd0,
                      4'b0010, 4'b0010, 32'h00001300, 1'b0, 1'b0));        // read-before-write
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0010, 32'h00000300, 1'b0, 8'h00, 9'd0,
                      4'b0010, 4'b0010, 32'h00007700, 1'b0, 1'b0));        // new value now
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0001, 32'h00000004, 1'b1, 8'h00, 9'd3,
                      4'b0001, 4'b0001, 32'h00000004, 1'b1, 1'b0));        // start + host read
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 8'h00, 9'd0,
                      4'b0001, 4'b0001, 32'h00000000, 1'b1, 1'b0));        // t=0 reads
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b1111, 32'h06060606, 1'b0, 8'h00, 9'd0,
                      4'b0011, 4'b0011, 32'h00001001, 1'b1, 1'b0));        // host rd ignored
      vq.push_back(mk(4'b0001, 32'h00000002, 32'h000000EE, 4'b0000, 32'h0, 1'b0, 8'h00, 9'd0,
                      4'b0111, 4'b0111, 32'h00201102, 1'b1, 1'b0));        // stream collision
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1, 8'h40, 9'd5,
                      4'b1110, 4'b1110, 32'h30211200, 1'b1, 1'b0));        // 2nd start ignored
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 8'h00, 9'd0,
                      4'b1100, 4'b1100, 32'h31220000, 1'b1, 1'b0));
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 8'h00, 9'd0,
                      4'b1000, 4'b1000, 32'h32000000, 1'b1, 1'b1));        // drain + done
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0001, 32'h00000002, 1'b0, 8'h00, 9'd0,
                      4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0));               // rd in drain ignored
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0001, 32'h00000002, 1'b0, 8'h00, 9'd0,
                      4'b0001, 4'b0001, 32'h000000EE, 1'b0, 1'b0));        // stream write landed
      vq.push_back(mk(4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 8'h00, 9'd0,
                      4'b0000, 4'b1111, 32'h322212EE, 1'b0, 1'b0));        // data holds

      for (int k = 0; k < vq.size(); k++) begin
         bus.wr_en = vq[k].wr_en; bus.wr_addr = vq[k].wr_addr; bus.wr_data = vq[k].wr_data;
         bus.rd_en = vq[k].rd_en; bus.rd_addr = vq[k].rd_addr;
         bus.stream_start = vq[k].start; bus.stream_base = vq[k].base; bus.stream_len = vq[k].len;
         step();
         chk($sformatf("v%0d_valid", k), 32'(bus.rd_valid), 32'(vq[k].exp_valid));
         chk($sformatf("v%0d_busy", k), 32'(bus.stream_busy), 32'(vq[k].exp_busy));
         chk($sformatf("v%0d_done", k), 32'(bus.stream_done), 32'(vq[k].exp_done));
         for (int i = 0; i < 4; i++) begin
            if (vq[k].chk_lanes[i]) begin
               chk($sformatf("v%0d_lane%0d", k, i), 32'(bus.rd_data[i*8 +: 8]),
                   32'(vq[k].exp_data[i*8 +: 8]));
            end
         end
      end
      idle_inputs();
      chk("table_done_count", 32'(done_cnt), 32'd1);

      // Row wrap past the top of each bank.
      stream_chk("wrap", 8'hFE, 4);

      // Empty stream.
      bus.stream_start = 1'b1; bus.stream_base = 8'h00; bus.stream_len = 9'd0;
      step();
      idle_inputs();
      chk("len0_busy", 32'(bus.stream_busy), 32'h1);
      chk("len0_done", 32'(bus.stream_done), 32'h1);
      chk("len0_valid", 32'(bus.rd_valid), 32'h0);
      step();
      chk("len0_after_busy", 32'(bus.stream_busy), 32'h0);
      chk("len0_after_done", 32'(bus.stream_done), 32'h0);
      chk("len0_after_valid", 32'(bus.rd_valid), 32'h0);

      // Reset mid-stream at t=2 of a len=8 stream.
      bus.stream_start = 1'b1; bus.stream_base = 8'h00; bus.stream_len = 9'd8;
      step();
      idle_inputs();
      step();
      step();
      chk("pre_rst_busy", 32'(bus.stream_busy), 32'h1);
      done_before = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_data", bus.rd_data, 32'h0);
      chk("mid_rst_valid", 32'(bus.rd_valid), 32'h0);
      chk("mid_rst_busy", 32'(bus.stream_busy), 32'h0);
      chk("mid_rst_done", 32'(bus.stream_done), 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("mid_rst_no_done", 32'(done_cnt), 32'(done_before));
      chk("post_rst_busy", 32'(bus.stream_busy), 32'h0);
      stream_chk("recover", 8'h04, 2);

      chk("final_done_count", 32'(done_cnt), 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end
endmodule
